x_mem_responder: RTL and testbench

- Memory-side responder for the core's single-outstanding request bus (valid / rnw / addr / data from the initiator; accept / data back to it).
- Holds a word-addressed RAM and answers each fetch, load or store after a fixed, parameterised number of wait states.
- Sits between x_top_rv32i and the peripheral fabric; also serves as the bench memory model for the core.

---
 rtl/x_mem_responder.sv | 101 ++++++++++
 tb/tb_x_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/x_mem_responder.sv
// rtl/x_mem_responder.sv - word-addressed RAM responder with fixed wait states for the single-outstanding request bus
module x_mem_responder #(
  parameter int          DEPTH    = 256,
  parameter int          WAIT     = 1,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  output logic        o_err,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          req_rnw;
  logic [AW-1:0] req_idx;
  logic [31:0]   req_wdata;
  logic          req_in_range;
  logic [31:0]   data_q;
  logic [31:0]   mem [DEPTH];

  logic          addr_in_range;
  logic          unused_addr_lsbs;

  // Byte-lane bits are ignored: every request is forced to word alignment.
  assign unused_addr_lsbs = &{1'b0, i_addr[1:0]};

  // An address is in range when no bit above the word index is set.
  assign addr_in_range = (i_addr[31:AW+2] == '0);

  // Request sequencing: latch once on IDLE->BUSY, count wait states, capture read data on BUSY->RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      req_rnw      <= 1'b0;
      req_idx      <= '0;
      req_wdata    <= 32'd0;
      req_in_range <= 1'b0;
      data_q       <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            req_rnw      <= i_rnw;
            req_idx      <= i_addr[AW+1:2];
            req_wdata    <= i_data;
            req_in_range <= addr_in_range;
            wait_cnt     <= 4'(WAIT);
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
            if (req_rnw) begin
              data_q <= req_in_range ? mem[req_idx] : ERR_DATA;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage: cleared on reset, written only at the end of an in-range write's RESP cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if ((state == ST_RESP) && !req_rnw && req_in_range) begin
      mem[req_idx] <= req_wdata;
    end
  end

  assign o_accept = (state == ST_RESP);
  assign o_err    = (state == ST_RESP) && !req_in_range;
  assign o_data   = data_q;
  assign o_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_x_mem_responder.sv
// tb/tb_x_mem_responder.sv - randomized self-checking bench for x_mem_responder against a word-array model
module tb_x_mem_responder;

  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid  [3];
  logic        rnw    [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        accept [3];
  logic [31:0] rdata  [3];
  logic        err    [3];
  logic        busy   [3];

  int          waits  [3];
  logic [31:0] model  [3][256];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    x_mem_responder #(
      .DEPTH    (256),
      .WAIT     (g == 0 ? 1 : (g == 1 ? 0 : 15)),
      .ERR_DATA (32'hDEADBEEF)
    ) u_dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (valid[g]),
      .i_rnw    (rnw[g]),
      .i_addr   (addr[g]),
      .i_data   (wdata[g]),
      .o_accept (accept[g]),
      .o_data   (rdata[g]),
      .o_err    (err[g]),
      .o_busy   (busy[g])
    );
  end

  function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
    if (a >= 32'd1024) return ERR;
    return model[k][a / 4];
  endfunction

  function automatic void model_write(input int k, input logic [31:0] a, input logic [31:0] d);
    if (a < 32'd1024) model[k][a / 4] = d;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 256; i++) model[k][i] = 32'd0;
  endfunction

  // Drive one request and record latency, response and per-cycle busy; lat = -1 on timeout.
  task automatic do_req(input int k, input logic r, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] od, output logic oe, output int lat,
                        output logic [63:0] btrace);
    od = 32'd0; oe = 1'b0; lat = -1; btrace = 64'd0;
    @(negedge clk);
    valid[k] = 1'b1; rnw[k] = r; addr[k] = a; wdata[k] = d;
    for (int n = 0; n < 40; n++) begin
      btrace[n] = busy[k];
      if (accept[k]) begin
        lat = n; od = rdata[k]; oe = err[k];
        break;
      end
      @(negedge clk);
    end
    valid[k] = 1'b0;
    if (lat >= 0) begin
      if (!r) model_write(k, a, d);
      @(negedge clk);
      btrace[lat + 1] = busy[k];
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks += 4;
      if (accept[k] !== 1'b0) begin n_fail++; $display("FAIL reset_accept[%0d] got %b want 0", k, accept[k]); end
      if (err[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d] got %b want 0", k, err[k]); end
      if (rdata[k] !== 32'd0) begin n_fail++; $display("FAIL reset_data[%0d] got %h want 0", k, rdata[k]); end
      if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", k, busy[k]); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] od; logic oe; int lat; logic [63:0] bt;
    logic [31:0] addrs [4] = '{32'h10, 32'h10, 32'h13, 32'h14};
    do_req(0, 1'b0, 32'h10, 32'h12345678, od, oe, lat, bt);
    n_checks += 2;
    if (lat != 3) begin n_fail++; $display("FAIL wr_latency got %0d want 3", lat); end
    if (oe !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", oe); end
    for (int i = 1; i < 4; i++) begin
      do_req(0, 1'b1, addrs[i], 32'd0, od, oe, lat, bt);
      n_checks += 3;
      if (lat != 3) begin n_fail++; $display("FAIL rd_latency addr=%h got %0d want 3", addrs[i], lat); end
      if (od !== model_read(0, addrs[i])) begin n_fail++; $display("FAIL rd_data addr=%h got %h want %h", addrs[i], od, model_read(0, addrs[i])); end
      if (oe !== 1'b0) begin n_fail++; $display("FAIL rd_err addr=%h got %b want 0", addrs[i], oe); end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] od; logic oe; int lat; logic [63:0] bt;
    do_req(0, 1'b1, 32'h400, 32'd0, od, oe, lat, bt);
    n_checks += 2;
    if (od !== ERR) begin n_fail++; $display("FAIL oor_rd_data got %h want %h", od, ERR); end
    if (oe !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err got %b want 1", oe); end
    do_req(0, 1'b0, 32'h400, 32'hAA, od, oe, lat, bt);
    n_checks += 1;
    if (oe !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err got %b want 1", oe); end
    do_req(0, 1'b1, 32'h0, 32'd0, od, oe, lat, bt);
    n_checks += 2;
    if (od !== 32'd0) begin n_fail++; $display("FAIL oor_wr_dropped got %h want 0", od); end
    if (oe !== 1'b0) begin n_fail++; $display("FAIL oor_after_err got %b want 0", oe); end
  endtask

  task automatic test_latency();
    logic [31:0] od; logic oe; int lat; logic [63:0] bt, exp_bt;
    for (int k = 1; k < 3; k++) begin
      do_req(k, 1'b1, 32'h20, 32'd0, od, oe, lat, bt);
      exp_bt = ((64'd1 << (waits[k] + 3)) - 64'd1) & ~64'd1 & ~(64'd1 << (waits[k] + 3 - 1 + 1));
      exp_bt = exp_bt & ~(64'd1 << (waits[k] + 3));
      n_checks += 3;
      if (lat != waits[k] + 2) begin n_fail++; $display("FAIL latency_wait%0d got %0d want %0d", waits[k], lat, waits[k] + 2); end
      if (bt !== exp_bt) begin n_fail++; $display("FAIL busy_trace_wait%0d got %h want %h", waits[k], bt, exp_bt); end
      if (od !== model_read(k, 32'h20)) begin n_fail++; $display("FAIL latency_data_wait%0d got %h want %h", waits[k], od, model_read(k, 32'h20)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] od; logic oe; int lat; logic [63:0] bt;
    logic [31:0] d0, d1, got0, got1;
    int t, t0, t1;
    d0 = $urandom; d1 = $urandom;
    do_req(0, 1'b0, 32'h0, d0, od, oe, lat, bt);
    do_req(0, 1'b0, 32'h4, d1, od, oe, lat, bt);
    t0 = -1; t1 = -1; got0 = 32'd0; got1 = 32'd0;
    @(negedge clk);
    valid[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 32'h0;
    for (t = 0; t < 60; t++) begin
      if (accept[0]) begin
        if (t0 < 0) begin
          t0 = t; got0 = rdata[0]; addr[0] = 32'h4;
        end else begin
          t1 = t; got1 = rdata[0];
          break;
        end
      end
      @(negedge clk);
    end
    valid[0] = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (t1 < 0 || t1 - t0 != waits[0] + 3) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", t1 - t0, waits[0] + 3); end
    if (got0 !== model_read(0, 32'h0)) begin n_fail++; $display("FAIL b2b_data0 got %h want %h", got0, model_read(0, 32'h0)); end
    if (got1 !== model_read(0, 32'h4)) begin n_fail++; $display("FAIL b2b_data1 got %h want %h", got1, model_read(0, 32'h4)); end
  endtask

  task automatic test_reset_midway();
    logic [31:0] od; logic oe; int lat; logic [63:0] bt;
    logic saw_accept;
    @(negedge clk);
    valid[0] = 1'b1; rnw[0] = 1'b0; addr[0] = 32'h8; wdata[0] = 32'h55;
    @(negedge clk);
    n_checks += 1;
    if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", busy[0]); end
    rst = 1'b1; valid[0] = 1'b0;
    model_clear();
    saw_accept = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (accept[0]) saw_accept = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (saw_accept !== 1'b0) begin n_fail++; $display("FAIL midrst_accept got %b want 0", saw_accept); end
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got busy=%b want 0", busy[0]); end
    do_req(0, 1'b1, 32'h8, 32'd0, od, oe, lat, bt);
    n_checks += 2;
    if (od !== 32'd0) begin n_fail++; $display("FAIL midrst_read8 got %h want 0", od); end
    if (lat != waits[0] + 2) begin n_fail++; $display("FAIL midrst_latency got %0d want %0d", lat, waits[0] + 2); end
  endtask

  task automatic test_random();
    logic [31:0] od; logic oe; int lat; logic [63:0] bt;
    logic r; logic [31:0] a, d;
    for (int i = 0; i < 60; i++) begin
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
      d = $urandom;
      if (r) begin
        do_req(0, r, a, d, od, oe, lat, bt);
        n_checks += 1;
        if (od !== model_read(0, a)) begin n_fail++; $display("FAIL rand_rd_data addr=%h got %h want %h", a, od, model_read(0, a)); end
      end else begin
        do_req(0, r, a, d, od, oe, lat, bt);
      end
      n_checks += 2;
      if (oe !== (a >= 32'd1024)) begin n_fail++; $display("FAIL rand_err addr=%h got %b want %b", a, oe, (a >= 32'd1024)); end
      if (lat != waits[0] + 2) begin n_fail++; $display("FAIL rand_latency addr=%h got %0d want %0d", a, lat, waits[0] + 2); end
    end
  endtask

  initial begin
    waits[0] = 1; waits[1] = 0; waits[2] = 15;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0; rnw[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_write_read();
    test_out_of_range();
    test_latency();
    test_back_to_back();
    test_reset_midway();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
